// File: rtl/eeg_pea_feed.sv
// Operand join-and-buffer stage feeding the EEG PE array: per-column atomic act/weight join into per-PE FWFT FIFOs.
// Optional zero-operand skipping is enabled by defining EEG_PEA_FEED_ZSKIP_EN.
module eeg_pea_feed #(
   parameter int unsigned PE_ROW    = 4,
   parameter int unsigned PE_COL    = 4,
   parameter int unsigned ACT_DW    = 8,
   parameter int unsigned WEI_DW    = 8,
   parameter int unsigned ACT_IW    = 12,
   parameter int unsigned WEI_IW    = 3,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       i_clr,
   input  logic [PE_ROW-1:0]                          i_cfg_row_en,
   input  logic [PE_COL-1:0]                          i_act_vld,
   output logic [PE_COL-1:0]                          o_act_rdy,
   input  logic [PE_COL-1:0]                          i_act_lst,
   input  logic [PE_COL-1:0][ACT_DW-1:0]              i_act_dat,
   input  logic [PE_COL-1:0][ACT_IW-1:0]              i_act_inf,
   input  logic [PE_COL-1:0][PE_ROW-1:0]              i_wei_vld,
   output logic [PE_COL-1:0][PE_ROW-1:0]              o_wei_rdy,
   input  logic [PE_COL-1:0][PE_ROW-1:0]              i_wei_lst,
   input  logic [PE_COL-1:0][PE_ROW-1:0][WEI_DW-1:0]  i_wei_dat,
   input  logic [PE_COL-1:0][PE_ROW-1:0][WEI_IW-1:0]  i_wei_inf,
   output logic [PE_ROW-1:0][PE_COL-1:0]              o_din_vld,
   input  logic [PE_ROW-1:0][PE_COL-1:0]              i_din_rdy,
   output logic [PE_ROW-1:0][PE_COL-1:0][ACT_DW-1:0]  o_din_act_dat,
   output logic [PE_ROW-1:0][PE_COL-1:0][WEI_DW-1:0]  o_din_wei_dat,
   output logic [PE_ROW-1:0][PE_COL-1:0][ACT_IW-1:0]  o_din_act_inf,
   output logic [PE_ROW-1:0][PE_COL-1:0][WEI_IW-1:0]  o_din_wei_inf,
   output logic [PE_ROW-1:0][PE_COL-1:0]              o_din_act_lst,
   output logic [PE_ROW-1:0][PE_COL-1:0]              o_din_wei_lst,
   output logic                                       o_is_idle,
   output logic [15:0]                                o_skp_cnt
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 2 + WEI_IW + ACT_IW + WEI_DW + ACT_DW;

   logic [PE_ROW-1:0][PE_COL-1:0] w_full;
   logic [PE_ROW-1:0][PE_COL-1:0] w_empty;
   logic [PE_ROW-1:0][PE_COL-1:0] w_push;
   logic [PE_ROW-1:0][PE_COL-1:0] w_pop;
   logic [PE_ROW-1:0][PE_COL-1:0] w_skip;
   logic [PE_COL-1:0]             w_free;
   logic [PE_COL-1:0]             w_allw;
   logic [PE_COL-1:0]             w_fire;
   logic                          w_block;

   assign w_block   = i_clr | rst;
   assign w_pop     = o_din_vld & i_din_rdy;
   assign o_is_idle = &w_empty;

   // Column join: a column fires only when every enabled row can accept and has its weight.
   always_comb begin : col_join
      w_free    = '1;
      w_allw    = '1;
      o_act_rdy = '0;
      o_wei_rdy = '0;
      w_fire    = '0;
      w_push    = '0;
      for (int j = 0; j < int'(PE_COL); j++) begin
         for (int i = 0; i < int'(PE_ROW); i++) begin
            if (i_cfg_row_en[i] && w_full[i][j])
               w_free[j] = 1'b0;
            if (i_cfg_row_en[i] && !i_wei_vld[j][i])
               w_allw[j] = 1'b0;
         end
         o_act_rdy[j] = w_free[j] & w_allw[j] & ~w_block;
         w_fire[j]    = i_act_vld[j] & o_act_rdy[j];
         for (int i = 0; i < int'(PE_ROW); i++) begin
            o_wei_rdy[j][i] = i_cfg_row_en[i] & i_act_vld[j] & o_act_rdy[j];
            w_push[i][j]    = w_fire[j] & i_cfg_row_en[i] & ~w_skip[i][j];
         end
      end
   end

`ifdef EEG_PEA_FEED_ZSKIP_EN
   logic [15:0] r_skp_cnt;
   logic [15:0] w_skp_inc;
   logic [16:0] w_skp_sum;

   // Zero-operand pairs are dropped unless they carry a last flag that downstream must see.
   always_comb begin : zskip_detect
      w_skip = '0;
      for (int j = 0; j < int'(PE_COL); j++) begin
         for (int i = 0; i < int'(PE_ROW); i++) begin
            w_skip[i][j] = ((i_act_dat[j] == '0) | (i_wei_dat[j][i] == '0))
                           & ~i_act_lst[j] & ~i_wei_lst[j][i];
         end
      end
   end

   always_comb begin : zskip_count
      w_skp_inc = '0;
      for (int j = 0; j < int'(PE_COL); j++) begin
         for (int i = 0; i < int'(PE_ROW); i++) begin
            if (w_fire[j] && i_cfg_row_en[i] && w_skip[i][j])
               w_skp_inc = w_skp_inc + 16'd1;
         end
      end
      w_skp_sum = 17'(r_skp_cnt) + 17'(w_skp_inc);
   end

   always_ff @(posedge clk) begin : skp_q
      if (rst || i_clr)
         r_skp_cnt <= '0;
      else
         r_skp_cnt <= w_skp_sum[16] ? 16'hFFFF : w_skp_sum[15:0];
   end

   assign o_skp_cnt = r_skp_cnt;
`else
   assign w_skip    = '0;
   assign o_skp_cnt = '0;
`endif

   for (genvar gi = 0; gi < int'(PE_ROW); gi++) begin : g_row
      for (genvar gj = 0; gj < int'(PE_COL); gj++) begin : g_col
         logic [ENT_W-1:0] r_mem [BUF_DEPTH];
         logic [PTR_W-1:0] r_wptr;
         logic [PTR_W-1:0] r_rptr;
         logic [CNT_W-1:0] r_cnt;
         logic [ENT_W-1:0] w_wr_ent;

         assign w_wr_ent = {i_wei_lst[gj][gi], i_act_lst[gj], i_wei_inf[gj][gi],
                            i_act_inf[gj], i_wei_dat[gj][gi], i_act_dat[gj]};

         // Pointers wrap naturally because the depth is a power of two.
         always_ff @(posedge clk) begin : ptr_q
            if (rst || i_clr) begin
               r_wptr <= '0;
               r_rptr <= '0;
               r_cnt  <= '0;
            end else begin
               if (w_push[gi][gj])
                  r_wptr <= r_wptr + PTR_W'(1);
               if (w_pop[gi][gj])
                  r_rptr <= r_rptr + PTR_W'(1);
               case ({w_push[gi][gj], w_pop[gi][gj]})
                  2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                  2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                  default: r_cnt <= r_cnt;
               endcase
            end
         end

         always_ff @(posedge clk) begin : mem_q
            if (w_push[gi][gj])
               r_mem[r_wptr] <= w_wr_ent;
         end

         assign w_full[gi][gj]    = (r_cnt == CNT_W'(BUF_DEPTH));
         assign w_empty[gi][gj]   = (r_cnt == '0);
         assign o_din_vld[gi][gj] = ~w_empty[gi][gj];
         assign {o_din_wei_lst[gi][gj], o_din_act_lst[gi][gj], o_din_wei_inf[gi][gj],
                 o_din_act_inf[gi][gj], o_din_wei_dat[gi][gj], o_din_act_dat[gi][gj]} = r_mem[r_rptr];
      end
   end

endmodule

// File: tb/tb_eeg_pea_feed.sv
// Directed self-checking bench for eeg_pea_feed (4x4 array, depth 4).
module tb_eeg_pea_feed;

   localparam int PE_ROW = 4;
   localparam int PE_COL = 4;
   localparam int ACT_DW = 8;
   localparam int WEI_DW = 8;
   localparam int ACT_IW = 12;
   localparam int WEI_IW = 3;
   localparam int BUF_DEPTH = 4;

`ifdef EEG_PEA_FEED_ZSKIP_EN
   localparam int          EXP_ENT = 7;
   localparam logic [15:0] EXP_SKP = 16'd4;
`else
   localparam int          EXP_ENT = 8;
   localparam logic [15:0] EXP_SKP = 16'd0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic [PE_ROW-1:0]                         cfg_row_en = '1;
   logic [PE_COL-1:0]                         act_vld = '0;
   logic [PE_COL-1:0]                         act_rdy;
   logic [PE_COL-1:0]                         act_lst = '0;
   logic [PE_COL-1:0][ACT_DW-1:0]             act_dat = '0;
   logic [PE_COL-1:0][ACT_IW-1:0]             act_inf = '0;
   logic [PE_COL-1:0][PE_ROW-1:0]             wei_vld = '0;
   logic [PE_COL-1:0][PE_ROW-1:0]             wei_rdy;
   logic [PE_COL-1:0][PE_ROW-1:0]             wei_lst = '0;
   logic [PE_COL-1:0][PE_ROW-1:0][WEI_DW-1:0] wei_dat = '0;
   logic [PE_COL-1:0][PE_ROW-1:0][WEI_IW-1:0] wei_inf = '0;
   logic [PE_ROW-1:0][PE_COL-1:0]             din_vld;
   logic [PE_ROW-1:0][PE_COL-1:0]             din_rdy = '0;
   logic [PE_ROW-1:0][PE_COL-1:0][ACT_DW-1:0] din_act_dat;
   logic [PE_ROW-1:0][PE_COL-1:0][WEI_DW-1:0] din_wei_dat;
   logic [PE_ROW-1:0][PE_COL-1:0][ACT_IW-1:0] din_act_inf;
   logic [PE_ROW-1:0][PE_COL-1:0][WEI_IW-1:0] din_wei_inf;
   logic [PE_ROW-1:0][PE_COL-1:0]             din_act_lst;
   logic [PE_ROW-1:0][PE_COL-1:0]             din_wei_lst;
   logic                                      is_idle;
   logic [15:0]                               skp_cnt;

   int checks   = 0;
   int failures = 0;

   eeg_pea_feed #(
      .PE_ROW(PE_ROW), .PE_COL(PE_COL), .ACT_DW(ACT_DW), .WEI_DW(WEI_DW),
      .ACT_IW(ACT_IW), .WEI_IW(WEI_IW), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .i_clr(clr), .i_cfg_row_en(cfg_row_en),
      .i_act_vld(act_vld), .o_act_rdy(act_rdy), .i_act_lst(act_lst),
      .i_act_dat(act_dat), .i_act_inf(act_inf),
      .i_wei_vld(wei_vld), .o_wei_rdy(wei_rdy), .i_wei_lst(wei_lst),
      .i_wei_dat(wei_dat), .i_wei_inf(wei_inf),
      .o_din_vld(din_vld), .i_din_rdy(din_rdy),
      .o_din_act_dat(din_act_dat), .o_din_wei_dat(din_wei_dat),
      .o_din_act_inf(din_act_inf), .o_din_wei_inf(din_wei_inf),
      .o_din_act_lst(din_act_lst), .o_din_wei_lst(din_wei_lst),
      .o_is_idle(is_idle), .o_skp_cnt(skp_cnt)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; act_vld = '1; wei_vld = '1; din_rdy = '1;
      step(); step();
      #1;
      checks++; if (act_rdy !== 4'h0) begin failures++; $display("FAIL rst_act_rdy got=%h exp=0", act_rdy); end
      checks++; if (wei_rdy !== 16'h0) begin failures++; $display("FAIL rst_wei_rdy got=%h exp=0", wei_rdy); end
      checks++; if (din_vld !== 16'h0) begin failures++; $display("FAIL rst_din_vld got=%h exp=0", din_vld); end
      checks++; if (is_idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", is_idle); end
      checks++; if (skp_cnt !== 16'h0) begin failures++; $display("FAIL rst_skp got=%h exp=0", skp_cnt); end
      rst = 1'b0; act_vld = '0; wei_vld = '0; din_rdy = '0;
      step();
      checks++; if (din_vld !== 16'h0 || is_idle !== 1'b1) begin failures++; $display("FAIL post_rst_idle vld=%h idle=%b exp 0/1", din_vld, is_idle); end
   endtask

   task automatic test_single_pair();
      logic [33:0] exp_ent;
      logic [33:0] got_ent;
      act_dat[0] = 8'h12; act_inf[0] = 12'hABC; act_lst[0] = 1'b1;
      for (int r = 0; r < PE_ROW; r++) begin
         wei_dat[0][r] = 8'h05; wei_inf[0][r] = 3'(r + 1); wei_lst[0][r] = r[0];
      end
      act_vld[0] = 1'b1; wei_vld[0] = 4'hF;
      #1;
      checks++; if (act_rdy !== 4'b0001) begin failures++; $display("FAIL single_act_rdy got=%h exp=1", act_rdy); end
      checks++; if (wei_rdy !== 16'h000F) begin failures++; $display("FAIL single_wei_rdy got=%h exp=000f", wei_rdy); end
      checks++; if (din_vld !== 16'h0) begin failures++; $display("FAIL single_no_bypass got=%h exp=0", din_vld); end
      step();
      act_vld = '0; wei_vld = '0;
      checks++; if (din_vld !== 16'h1111) begin failures++; $display("FAIL single_din_vld got=%h exp=1111", din_vld); end
      for (int r = 0; r < PE_ROW; r++) begin
         exp_ent = {1'b1, r[0], 12'hABC, 3'(r + 1), 8'h12, 8'h05};
         got_ent = {din_act_lst[r][0], din_wei_lst[r][0], din_act_inf[r][0], din_wei_inf[r][0],
                    din_act_dat[r][0], din_wei_dat[r][0]};
         checks++; if (got_ent !== exp_ent) begin failures++; $display("FAIL single_payload row%0d got=%h exp=%h", r, got_ent, exp_ent); end
      end
      din_rdy = '1;
      step();
      din_rdy = '0; act_lst = '0; wei_lst = '0;
      checks++; if (din_vld !== 16'h0 || is_idle !== 1'b1) begin failures++; $display("FAIL single_drain vld=%h idle=%b exp 0/1", din_vld, is_idle); end
   endtask

   task automatic test_backpressure();
      int  nf;
      logic fired;
      nf = 0;
      din_rdy = '1; din_rdy[2][1] = 1'b0;
      act_dat[1] = 8'h20; wei_dat[1] = {4{8'h09}};
      act_vld[1] = 1'b1; wei_vld[1] = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         fired = act_vld[1] & act_rdy[1];
         step();
         if (fired) begin
            nf++;
            act_dat[1] = 8'(32'h20 + nf);
         end
      end
      #1;
      checks++; if (nf !== 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", nf); end
      checks++; if (act_rdy[1] !== 1'b0) begin failures++; $display("FAIL bp_act_rdy_full got=%b exp=0", act_rdy[1]); end
      checks++; if (wei_rdy[1] !== 4'h0) begin failures++; $display("FAIL bp_wei_rdy_full got=%h exp=0", wei_rdy[1]); end
      din_rdy[2][1] = 1'b1;
      #1;
      checks++; if (act_rdy[1] !== 1'b0) begin failures++; $display("FAIL bp_pop_no_admit got=%b exp=0", act_rdy[1]); end
      step();
      din_rdy[2][1] = 1'b0;
      #1;
      checks++; if (act_rdy[1] !== 1'b1) begin failures++; $display("FAIL bp_after_pop got=%b exp=1", act_rdy[1]); end
      step();
      act_vld = '0; wei_vld = '0;
      #1;
      checks++; if (dut.g_row[2].g_col[1].r_cnt !== 3'd4) begin failures++; $display("FAIL bp_one_more got=%0d exp=4", dut.g_row[2].g_col[1].r_cnt); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (din_vld[2][1] !== 1'b1 || din_act_dat[2][1] !== 8'(32'h21 + k)) begin
            failures++; $display("FAIL bp_order k%0d vld=%b got=%h exp=%h", k, din_vld[2][1], din_act_dat[2][1], 8'(32'h21 + k));
         end
         din_rdy[2][1] = 1'b1;
         step();
      end
      din_rdy = '0;
      checks++; if (is_idle !== 1'b1) begin failures++; $display("FAIL bp_drained got=%b exp=1", is_idle); end
   endtask

   task automatic test_missing_weight();
      din_rdy = '0;
      act_dat[3] = 8'h33; wei_dat[3] = {4{8'h44}};
      act_vld[3] = 1'b1; wei_vld[3] = 4'b1011;
      #1;
      checks++; if (act_rdy[3] !== 1'b0 || wei_rdy[3] !== 4'h0) begin failures++; $display("FAIL mw_blocked act=%b wei=%h exp 0/0", act_rdy[3], wei_rdy[3]); end
      step();
      checks++; if (din_vld !== 16'h0) begin failures++; $display("FAIL mw_no_write got=%h exp=0", din_vld); end
      wei_vld[3][2] = 1'b1;
      #1;
      checks++; if (act_rdy[3] !== 1'b1 || wei_rdy[3] !== 4'hF) begin failures++; $display("FAIL mw_ready act=%b wei=%h exp 1/f", act_rdy[3], wei_rdy[3]); end
      step();
      act_vld = '0; wei_vld = '0;
      checks++; if (din_vld !== 16'h8888) begin failures++; $display("FAIL mw_atomic got=%h exp=8888", din_vld); end
      din_rdy = '1;
      step();
      din_rdy = '0;
      checks++; if (is_idle !== 1'b1) begin failures++; $display("FAIL mw_drain got=%b exp=1", is_idle); end
   endtask

   task automatic test_row_mask();
      cfg_row_en = 4'b0101;
      act_dat[0] = 8'h5A; wei_dat[0] = {4{8'h0C}};
      act_vld[0] = 1'b1; wei_vld[0] = 4'hF;
      #1;
      checks++; if (wei_rdy[0] !== 4'b0101) begin failures++; $display("FAIL mask_wei_rdy got=%b exp=0101", wei_rdy[0]); end
      step();
      act_vld = '0; wei_vld = '0;
      checks++; if (din_vld !== 16'h0101) begin failures++; $display("FAIL mask_din_vld got=%h exp=0101", din_vld); end
      din_rdy = '1;
      step();
      din_rdy = '0;
      cfg_row_en = 4'b0000;
      act_vld = '1;
      #1;
      checks++; if (act_rdy !== 4'hF || wei_rdy !== 16'h0) begin failures++; $display("FAIL mask_drain_rdy act=%h wei=%h exp f/0", act_rdy, wei_rdy); end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (is_idle !== 1'b1 || din_vld !== 16'h0) begin failures++; $display("FAIL mask_drain_idle c%0d idle=%b vld=%h exp 1/0", c, is_idle, din_vld); end
      end
      act_vld = '0;
      cfg_row_en = 4'hF;
   endtask

   task automatic test_zero_skip();
      int cnt [PE_ROW];
      for (int r = 0; r < PE_ROW; r++) cnt[r] = 0;
      for (int r = 0; r < PE_ROW; r++) din_rdy[r][0] = 1'b1;
      wei_dat[0] = {4{8'h07}}; wei_lst[0] = '0;
      for (int k = 1; k <= 8; k++) begin
         act_dat[0] = (k == 2 || k == 5) ? 8'h00 : 8'(32'h30 + k);
         act_lst[0] = (k == 5);
         act_vld[0] = 1'b1; wei_vld[0] = 4'hF;
         #1;
         checks++; if (act_rdy[0] !== 1'b1) begin failures++; $display("FAIL zs_rdy k%0d got=%b exp=1", k, act_rdy[0]); end
         step();
         for (int r = 0; r < PE_ROW; r++) cnt[r] += int'(din_vld[r][0]);
         if (k == 5) begin
            checks++;
            if ({din_vld[0][0], din_act_lst[0][0], din_act_dat[0][0]} !== {1'b1, 1'b1, 8'h00}) begin
               failures++; $display("FAIL zs_last_kept vld=%b lst=%b dat=%h exp 1/1/00", din_vld[0][0], din_act_lst[0][0], din_act_dat[0][0]);
            end
         end
      end
      act_vld = '0; wei_vld = '0; act_lst = '0;
      for (int c = 0; c < 2; c++) begin
         step();
         for (int r = 0; r < PE_ROW; r++) cnt[r] += int'(din_vld[r][0]);
      end
      for (int r = 0; r < PE_ROW; r++) begin
         checks++; if (cnt[r] !== EXP_ENT) begin failures++; $display("FAIL zs_entries row%0d got=%0d exp=%0d", r, cnt[r], EXP_ENT); end
      end
      checks++; if (skp_cnt !== EXP_SKP) begin failures++; $display("FAIL zs_skp_cnt got=%0d exp=%0d", skp_cnt, EXP_SKP); end
      din_rdy = '0;
   endtask

   task automatic test_clr_rst();
      for (int pass = 0; pass < 2; pass++) begin
         act_dat[2] = 8'h77; wei_dat[2] = {4{8'h11}};
         act_vld[2] = 1'b1; wei_vld[2] = 4'hF;
         for (int c = 0; c < 3; c++) step();
         checks++; if (din_vld !== 16'h4444 || is_idle !== 1'b0) begin failures++; $display("FAIL clr%0d_filled vld=%h idle=%b exp 4444/0", pass, din_vld, is_idle); end
         if (pass == 0) clr = 1'b1; else rst = 1'b1;
         #1;
         checks++; if (act_rdy !== 4'h0 || wei_rdy !== 16'h0) begin failures++; $display("FAIL clr%0d_rdy act=%h wei=%h exp 0/0", pass, act_rdy, wei_rdy); end
         step();
         clr = 1'b0; rst = 1'b0;
         act_vld = '0; wei_vld = '0;
         checks++; if (din_vld !== 16'h0 || is_idle !== 1'b1) begin failures++; $display("FAIL clr%0d_empty vld=%h idle=%b exp 0/1", pass, din_vld, is_idle); end
         checks++; if (skp_cnt !== 16'h0) begin failures++; $display("FAIL clr%0d_skp got=%h exp=0", pass, skp_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_single_pair();
      test_backpressure();
      test_missing_weight();
      test_row_mask();
      test_zero_skip();
      test_clr_rst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eeg_pea_feed.md
# eeg_pea_feed

Parametrised operand join-and-buffer stage sitting between the activation/weight fetch units and the PE array of the EEG convolution engine. Per column, one activation stream is broadcast to every enabled row and atomically joined with that column's per-row weight streams. Each joined pair is pushed into a per-PE FIFO of configurable depth. This generation adds a runtime row mask, an atomic column join with no partial writes, a clear input, idle status and optional zero-operand skipping.

## Interface
- PE_ROW, 4, PE rows per column
- PE_COL, 4, PE columns (activation streams)
- ACT_DW, 8, activation data width
- WEI_DW, 8, weight data width
- ACT_IW, 12, activation side-info width (ARAM address)
- WEI_IW, 3, weight side-info width (kernel index)
- BUF_DEPTH, 4, entries per PE FIFO; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- CLR  in  1  synchronous clear of all FIFOs
- CFG_ROW_EN  in  PE_ROW  row enable mask, shared by all columns; static while not IS_IDLE
- ACT_VLD / ACT_RDY / ACT_LST  in/out/in  PE_COL  activation handshake and last flag per column
- ACT_DAT, ACT_INF  in  PE_COL×ACT_DW, PE_COL×ACT_IW  activation payload
- WEI_VLD / WEI_RDY / WEI_LST  in/out/in  PE_COL×PE_ROW  weight handshake and last flag, indexed [col][row]
- WEI_DAT, WEI_INF  in  PE_COL×PE_ROW×WEI_DW / ×WEI_IW  weight payload
- DIN_VLD / DIN_RDY  out/in  PE_ROW×PE_COL  per-PE output handshake, indexed [row][col]
- DIN_ACT_DAT, DIN_WEI_DAT, DIN_ACT_INF, DIN_WEI_INF, DIN_ACT_LST, DIN_WEI_LST  out  per-PE payload from the FIFO head
- IS_IDLE  out  1  all FIFOs empty
- SKP_CNT  out  16  skipped-pair count (macro only; tied 0 otherwise)

## Operation
- Per-PE FIFO entry: {wei_lst, act_lst, wei_inf, act_inf, wei_dat, act_dat}. Head is first-word-fall-through from registered storage. Occupancy counter is clog2(BUF_DEPTH)+1 bits.
- Column j is free when every enabled row i has a non-full FIFO[i][j].
- Column j has all weights when every enabled row has WEI_VLD[j][i].
- ACT_RDY[j] = free_j & all-weights_j & ~CLR & ~rst.
- WEI_RDY[j][i] = CFG_ROW_EN[i] & ACT_VLD[j] & free_j & all-weights_j & ~CLR & ~rst.
- Disabled rows: WEI_RDY=0, weights ignored, FIFO never written.
- Column fire = ACT_VLD & ACT_RDY. On fire, every enabled row of that column pushes in the same cycle. There are never partial writes.
- Pop when DIN_VLD & DIN_RDY. DIN_VLD = ~empty.
- Per-PE order is preserved. Columns are independent, with no cross-column coupling.
- ACT_RDY/WEI_RDY depend on valids; valids must not depend on ready.
- CLR: next edge sets all pointers/counters to 0 (empty) and SKP_CNT to 0. A fire is impossible in the CLR cycle.
- All-rows-disabled: free and all-weights are vacuously true. An activation is consumed and discarded (drain mode).

## Timing
- Reset (and CLR): all FIFOs empty. DIN_VLD=0, ACT_RDY=0, WEI_RDY=0 during rst, IS_IDLE=1, SKP_CNT=0, DIN payload don't-care.
- Write latency: a fire at edge N gives DIN_VLD=1 from cycle N+1. There is no same-cycle bypass.
- Full: ready derives from not-full only, so a pop in the same cycle does not admit a write. Max throughput is 1 pair/cycle/PE for BUF_DEPTH≥2.
- Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged.
- Pointers wrap modulo BUF_DEPTH.
- rst mid-operation: all in-flight entries lost at the next edge, with no residual valids.
- IS_IDLE is combinational from the empty flags.

## Configuration
- EEG_PEA_FEED_ZSKIP_EN defined:
  - Per PE at fire, if act_dat==0 or wei_dat==0, and act_lst=0 and wei_lst=0, the pair is not pushed. The handshake still completes and SKP_CNT increments by the number of PEs skipped that cycle, saturating at 0xFFFF.
  - Zero pairs carrying a last flag are always pushed.
  - The free check is unchanged: all enabled FIFOs must be non-full regardless of skip.
- Undefined: every fired pair is pushed, SKP_CNT tied 0, no skip logic synthesised.

## Test plan
- Single pair: PE_ROW=PE_COL=4, all rows enabled, col 0 act=0x12, all weights 0x05, fire at cycle 10 -> DIN_VLD[0..3][0]=1 at cycle 11, payload act 0x12 / wei 0x05; other columns idle.
- Backpressure: BUF_DEPTH=4, DIN_RDY[2][1]=0, col 1 streams 6 pairs -> 4 accepted, then ACT_RDY[1]=0 and all WEI_RDY[1][*]=0. Row 2 DIN_RDY=1 for one cycle -> exactly one more fire, the cycle after the pop.
- Missing weight: WEI_VLD[3][2]=0, others valid -> no fire, no FIFO of col 3 written. Raising it -> fire writes all 4 rows in the same edge.
- Row mask: CFG_ROW_EN=4'b0101 -> WEI_RDY rows 1,3 stay 0, only FIFOs rows 0,2 fill. CFG_ROW_EN=0 -> activations consumed each cycle, IS_IDLE stays 1.
- CLR/rst mid-stream: 3 entries buffered, CLR pulse -> DIN_VLD all 0 and IS_IDLE=1 next cycle. Same with rst, plus ready=0 during rst.
- ZSKIP (macro on): 8 fires on col 0 with act=0 on fires 2,5 and act_lst on fire 5 -> each row receives 7 entries including the zero last entry, SKP_CNT=4.
